// File: rtl/spi_master_if.sv
// Bus between an SPI master and its client: word request/hold, serial pins, receive result.
// The master modport is the spi_master view; slave is the view of whatever drives it.
interface spi_master_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data;
    logic              data_ready;
    logic              en;
    logic              hold;
    logic              sdi;
    logic              sdo;
    logic              sclk;
    logic              cs;
    logic [DATA_W-1:0] rx_data;
    logic              done;
    logic              busy;

    modport master (
        input  data, data_ready, en, hold, sdi,
        output sdo, sclk, cs, rx_data, done, busy
    );

    modport slave (
        output data, data_ready, en, hold, sdi,
        input  sdo, sclk, cs, rx_data, done, busy
    );
endinterface

// File: rtl/spi_master.sv
// SPI master: one DATA_W word per accepted request, CPOL/CPHA/bit order fixed by parameters.
// Latency: done pulses CLK_DIV*(1+2*DATA_W)+1 cycles after acceptance; all outputs registered.
// Backpressure: requests arriving while busy are dropped, never queued; hold keeps cs low between words.
module spi_master #(
    parameter int DATA_W    = 8,
    parameter int CLK_DIV   = 2,
    parameter bit CPOL      = 1'b0,
    parameter bit CPHA      = 1'b0,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    spi_master_if.master bus
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, WAIT} state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic              half_q, half_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic              hold_q, hold_d;
    logic              cs_q, cs_d;
    logic              sclk_q, sclk_d;
    logic              sdo_q, sdo_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              accept;

    function automatic logic tx_bit(input logic [DATA_W-1:0] w, input logic [BIT_W-1:0] k);
        logic [BIT_W-1:0] idx;
        idx = MSB_FIRST ? (BIT_LAST - k) : k;
        return w[idx];
    endfunction

    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] r, input logic b);
        return MSB_FIRST ? {r[DATA_W-2:0], b} : {b, r[DATA_W-1:1]};
    endfunction

    assign accept = bus.data_ready && bus.en;

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_d     = bit_q;
        half_d    = half_q;
        tx_d      = tx_q;
        rx_sh_d   = rx_sh_q;
        hold_d    = hold_q;
        cs_d      = cs_q;
        sclk_d    = sclk_q;
        sdo_d     = sdo_q;
        done_d    = 1'b0;
        busy_d    = busy_q;
        rx_data_d = rx_data_q;

        case (state_q)
            IDLE, WAIT: begin
                if (accept) begin
                    state_d = SETUP;
                    div_d   = '0;
                    tx_d    = bus.data;
                    hold_d  = bus.hold;
                    cs_d    = 1'b0;
                    sclk_d  = CPOL;
                    sdo_d   = CPHA ? 1'b0 : tx_bit(bus.data, '0);
                    busy_d  = 1'b1;
                end else if (state_q == IDLE || !bus.hold) begin
                    state_d = IDLE;
                    cs_d    = 1'b1;
                end
            end
            SETUP: begin
                if (div_q == DIV_LAST) begin
                    state_d = SHIFT;
                    div_d   = '0;
                    half_d  = 1'b0;
                    bit_d   = '0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            SHIFT: begin
                if (div_q != DIV_LAST) begin
                    div_d = div_q + 1'b1;
                end else if (!half_q) begin
                    // Leading edge of the current bit.
                    div_d  = '0;
                    half_d = 1'b1;
                    sclk_d = ~CPOL;
                    if (CPHA) sdo_d   = tx_bit(tx_q, bit_q);
                    else      rx_sh_d = shift_in(rx_sh_q, bus.sdi);
                end else begin
                    // Trailing edge; on the last bit this edge is also the done cycle.
                    div_d  = '0;
                    half_d = 1'b0;
                    sclk_d = CPOL;
                    if (CPHA) rx_sh_d = shift_in(rx_sh_q, bus.sdi);
                    if (bit_q == BIT_LAST) begin
                        done_d    = 1'b1;
                        busy_d    = 1'b0;
                        sdo_d     = 1'b0;
                        rx_data_d = rx_sh_d;
                        if (hold_q) begin
                            state_d = WAIT;
                        end else begin
                            state_d = IDLE;
                            cs_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                        if (!CPHA) sdo_d = tx_bit(tx_q, bit_q + 1'b1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cs_d    = 1'b1;
                sclk_d  = CPOL;
                sdo_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            div_q     <= '0;
            bit_q     <= '0;
            half_q    <= 1'b0;
            tx_q      <= '0;
            rx_sh_q   <= '0;
            hold_q    <= 1'b0;
            cs_q      <= 1'b1;
            sclk_q    <= CPOL;
            sdo_q     <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            rx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            half_q    <= half_d;
            tx_q      <= tx_d;
            rx_sh_q   <= rx_sh_d;
            hold_q    <= hold_d;
            cs_q      <= cs_d;
            sclk_q    <= sclk_d;
            sdo_q     <= sdo_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            rx_data_q <= rx_data_d;
        end
    end

    assign bus.sdo     = sdo_q;
    assign bus.sclk    = sclk_q;
    assign bus.cs      = cs_q;
    assign bus.done    = done_q;
    assign bus.busy    = busy_q;
    assign bus.rx_data = rx_data_q;
endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: three configurations driven one at a time through a shared SPI slave model.
module tb_spi_master;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_master_if #(.DATA_W(8))  ia ();
    spi_master_if #(.DATA_W(8))  ib ();
    spi_master_if #(.DATA_W(32)) ic ();

    spi_master #(.DATA_W(8), .CLK_DIV(2), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1))
        dut_a (.clk(clk), .rst(rst), .bus(ia.master));
    spi_master #(.DATA_W(8), .CLK_DIV(2), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0))
        dut_b (.clk(clk), .rst(rst), .bus(ib.master));
    spi_master #(.DATA_W(32), .CLK_DIV(1), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1))
        dut_c (.clk(clk), .rst(rst), .bus(ic.master));

    int cfg_dw   [3] = '{8, 8, 32};
    int cfg_div  [3] = '{2, 2, 1};
    bit cfg_cpol [3] = '{1'b0, 1'b1, 1'b0};
    bit cfg_cpha [3] = '{1'b0, 1'b1, 1'b0};
    bit cfg_msb  [3] = '{1'b1, 1'b0, 1'b1};

    int          sel;
    logic [31:0] tx_drv;
    logic        dr, en_drv, hold_drv, sdi_drv, loop;
    int          vectors = 0;
    int          miscompares = 0;

    assign ia.data       = tx_drv[7:0];
    assign ib.data       = tx_drv[7:0];
    assign ic.data       = tx_drv;
    assign ia.data_ready = dr && (sel == 0);
    assign ib.data_ready = dr && (sel == 1);
    assign ic.data_ready = dr && (sel == 2);
    assign ia.en         = en_drv && (sel == 0);
    assign ib.en         = en_drv && (sel == 1);
    assign ic.en         = en_drv && (sel == 2);
    assign ia.hold       = hold_drv;
    assign ib.hold       = hold_drv;
    assign ic.hold       = hold_drv;
    assign ia.sdi        = loop ? ia.sdo : sdi_drv;
    assign ib.sdi        = loop ? ib.sdo : sdi_drv;
    assign ic.sdi        = loop ? ic.sdo : sdi_drv;

    logic        c_sdo, c_sclk, c_cs, c_done, c_busy;
    logic [31:0] c_rx;
    always_comb begin
        c_sdo = ic.sdo; c_sclk = ic.sclk; c_cs = ic.cs; c_done = ic.done; c_busy = ic.busy; c_rx = ic.rx_data;
        if (sel == 0) begin
            c_sdo = ia.sdo; c_sclk = ia.sclk; c_cs = ia.cs; c_done = ia.done; c_busy = ia.busy; c_rx = {24'h0, ia.rx_data};
        end else if (sel == 1) begin
            c_sdo = ib.sdo; c_sclk = ib.sclk; c_cs = ib.cs; c_done = ib.done; c_busy = ib.busy; c_rx = {24'h0, ib.rx_data};
        end
    end

    function automatic int bit_pos(input bit msb, input int dw, input int k);
        return msb ? (dw - 1 - k) : k;
    endfunction

    // One word on the selected master, observed from the pins as an SPI slave would see it.
    task automatic xfer(input logic [31:0] word_in, input logic [31:0] slv_in, input logic hold_v, input bit from_wait);
        int dw, dv, t_done, n_edges, k_tx, first_done, bad_cs, bad_busy, bad_edge;
        bit cpol, cpha, msb;
        logic [31:0] mask, word, slv, got, exp_rx, tmp;
        logic prev_sclk, prev_sdo;
        dw = cfg_dw[sel]; dv = cfg_div[sel];
        cpol = cfg_cpol[sel]; cpha = cfg_cpha[sel]; msb = cfg_msb[sel];
        mask = (dw == 32) ? 32'hFFFF_FFFF : ((32'd1 << dw) - 32'd1);
        word = word_in & mask;
        slv = slv_in & mask;
        exp_rx = loop ? word : slv;
        t_done = dv * (1 + 2 * dw) + 1;
        n_edges = 0; k_tx = 0; first_done = -1; bad_cs = 0; bad_busy = 0; bad_edge = 0;
        got = '0;
        if (from_wait) begin
            vectors++;
            if (c_cs !== 1'b0) begin miscompares++; $display("FAIL wait_cs: cs=%b expected 0", c_cs); end
        end
        prev_sclk = c_sclk;
        prev_sdo = c_sdo;
        tmp = slv >> bit_pos(msb, dw, 0);
        sdi_drv = cpha ? 1'b0 : tmp[0];
        tx_drv = word; hold_drv = hold_v; en_drv = 1'b1; dr = 1'b1;
        for (int n = 1; n <= t_done; n++) begin
            @(negedge clk);
            if (n == 1) dr = 1'b0;
            if (c_sclk !== prev_sclk) begin
                if (n != 2 * dv + 1 + n_edges * dv) bad_edge++;
                if ((n_edges % 2) == int'(cpha) && k_tx < dw) begin
                    got = got | (32'(prev_sdo) << bit_pos(msb, dw, k_tx));
                    k_tx++;
                end
                if ((n_edges % 2) != int'(cpha) && (n_edges + 1) / 2 < dw) begin
                    tmp = slv >> bit_pos(msb, dw, (n_edges + 1) / 2);
                    sdi_drv = tmp[0];
                end
                n_edges++;
            end
            if (n < t_done && c_cs !== 1'b0) bad_cs++;
            if (n < t_done && c_busy !== 1'b1) bad_busy++;
            if (c_done === 1'b1 && first_done < 0) first_done = n;
            prev_sclk = c_sclk;
            prev_sdo = c_sdo;
        end
        vectors++; if (n_edges != 2 * dw) begin miscompares++; $display("FAIL edge_count: got %0d expected %0d", n_edges, 2 * dw); end
        vectors++; if (bad_edge != 0) begin miscompares++; $display("FAIL edge_timing: %0d misplaced edges, expected 0", bad_edge); end
        vectors++; if (got !== word) begin miscompares++; $display("FAIL sdo_word: got %h expected %h", got, word); end
        vectors++; if (first_done != t_done) begin miscompares++; $display("FAIL done_cycle: got %0d expected %0d", first_done, t_done); end
        vectors++; if (c_rx !== exp_rx) begin miscompares++; $display("FAIL rx_data: got %h expected %h", c_rx, exp_rx); end
        vectors++; if (c_cs !== !hold_v) begin miscompares++; $display("FAIL done_cs: got %b expected %b", c_cs, !hold_v); end
        vectors++; if (c_sclk !== cpol) begin miscompares++; $display("FAIL done_sclk: got %b expected %b", c_sclk, cpol); end
        vectors++; if (c_sdo !== 1'b0 || c_busy !== 1'b0) begin miscompares++; $display("FAIL done_sdo_busy: got %b/%b expected 0/0", c_sdo, c_busy); end
        vectors++; if (bad_cs != 0) begin miscompares++; $display("FAIL cs_during: %0d cycles high, expected 0", bad_cs); end
        vectors++; if (bad_busy != 0) begin miscompares++; $display("FAIL busy_during: %0d cycles low, expected 0", bad_busy); end
    endtask

    task automatic test_reset();
        rst = 1'b1; dr = 1'b0; en_drv = 1'b0; hold_drv = 1'b0; sdi_drv = 1'b0; loop = 1'b0;
        tx_drv = '0; sel = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            vectors++; if (c_cs !== 1'b1) begin miscompares++; $display("FAIL reset_cs[%0d]: got %b expected 1", s, c_cs); end
            vectors++; if (c_sclk !== cfg_cpol[s]) begin miscompares++; $display("FAIL reset_sclk[%0d]: got %b expected %b", s, c_sclk, cfg_cpol[s]); end
            vectors++; if (c_sdo !== 1'b0) begin miscompares++; $display("FAIL reset_sdo[%0d]: got %b expected 0", s, c_sdo); end
            vectors++; if (c_done !== 1'b0 || c_busy !== 1'b0) begin miscompares++; $display("FAIL reset_done_busy[%0d]: got %b/%b expected 0/0", s, c_done, c_busy); end
            vectors++; if (c_rx !== 32'h0) begin miscompares++; $display("FAIL reset_rx[%0d]: got %h expected 0", s, c_rx); end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mode0();
        sel = 0; loop = 1'b1;
        @(negedge clk);
        xfer(32'hA5, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        vectors++; if (c_done !== 1'b0) begin miscompares++; $display("FAIL done_width: got %b expected 0", c_done); end
        loop = 1'b0;
        for (int i = 0; i < 3; i++) xfer($urandom, $urandom, 1'b0, 1'b0);
    endtask

    task automatic test_cpol1_cpha1_lsb();
        sel = 1; loop = 1'b0;
        @(negedge clk);
        vectors++; if (c_sclk !== 1'b1) begin miscompares++; $display("FAIL idle_sclk: got %b expected 1", c_sclk); end
        xfer(32'h3C, 32'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) xfer($urandom, $urandom, 1'b0, 1'b0);
    endtask

    task automatic test_hold();
        int cs_bad;
        sel = 0; loop = 1'b0; cs_bad = 0;
        @(negedge clk);
        xfer(32'h12, $urandom, 1'b1, 1'b0);
        xfer(32'h34, $urandom, 1'b1, 1'b1);
        repeat (3) begin
            @(negedge clk);
            if (c_cs !== 1'b0) cs_bad++;
        end
        vectors++; if (cs_bad != 0) begin miscompares++; $display("FAIL wait_hold_cs: %0d cycles high, expected 0", cs_bad); end
        hold_drv = 1'b0;
        @(negedge clk);
        vectors++; if (c_cs !== 1'b1) begin miscompares++; $display("FAIL hold_release_cs: got %b expected 1", c_cs); end
    endtask

    task automatic test_reset_mid();
        int dones, rx_bad;
        logic cs_mid, cs_after, sclk_after, busy_after;
        sel = 0; loop = 1'b0; hold_drv = 1'b0; dones = 0; rx_bad = 0;
        cs_mid = 1'b1; cs_after = 1'b0; sclk_after = 1'b1; busy_after = 1'b1;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        tx_drv = $urandom; en_drv = 1'b1; dr = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (n == 1) dr = 1'b0;
            if (n == 10) begin cs_mid = c_cs; rst = 1'b1; end
            if (n == 11) begin rst = 1'b0; cs_after = c_cs; sclk_after = c_sclk; busy_after = c_busy; end
            if (c_done === 1'b1) dones++;
            if (c_rx !== 32'h0) rx_bad++;
        end
        vectors++; if (cs_mid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_active: cs=%b expected 0", cs_mid); end
        vectors++; if (cs_after !== 1'b1 || sclk_after !== 1'b0) begin miscompares++; $display("FAIL rst_mid_pins: cs/sclk=%b/%b expected 1/0", cs_after, sclk_after); end
        vectors++; if (busy_after !== 1'b0) begin miscompares++; $display("FAIL rst_mid_busy: got %b expected 0", busy_after); end
        vectors++; if (dones != 0) begin miscompares++; $display("FAIL rst_mid_done: %0d pulses, expected 0", dones); end
        vectors++; if (rx_bad != 0) begin miscompares++; $display("FAIL rst_mid_rx: %0d cycles nonzero, expected 0", rx_bad); end
    endtask

    task automatic test_ignore();
        int dones, first, post_bad;
        logic [31:0] w;
        sel = 0; loop = 1'b1; hold_drv = 1'b0; dones = 0; first = -1; post_bad = 0;
        w = $urandom & 32'hFF;
        @(negedge clk);
        tx_drv = w; en_drv = 1'b1; dr = 1'b1;
        for (int n = 1; n <= 90; n++) begin
            @(negedge clk);
            if (n == 1) dr = 1'b0;
            if (n == 5) begin dr = 1'b1; tx_drv = ~w; end
            if (n == 6) dr = 1'b0;
            if (n == 12) en_drv = 1'b0;
            if (c_done === 1'b1) begin dones++; if (first < 0) first = n; end
            if (first > 0 && n > first && (c_cs !== 1'b1 || c_busy !== 1'b0)) post_bad++;
        end
        vectors++; if (dones != 1) begin miscompares++; $display("FAIL ignore_done_count: got %0d expected 1", dones); end
        vectors++; if (first != 35) begin miscompares++; $display("FAIL ignore_done_cycle: got %0d expected 35", first); end
        vectors++; if (c_rx !== w) begin miscompares++; $display("FAIL ignore_rx: got %h expected %h", c_rx, w); end
        vectors++; if (post_bad != 0) begin miscompares++; $display("FAIL ignore_second_xfer: %0d active cycles, expected 0", post_bad); end
    endtask

    task automatic test_back_to_back_w32();
        sel = 2; loop = 1'b1; hold_drv = 1'b0;
        @(negedge clk);
        xfer($urandom, 32'h0, 1'b0, 1'b0);
        loop = 1'b0;
        xfer($urandom, $urandom, 1'b0, 1'b0);
        xfer($urandom, $urandom, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_cpol1_cpha1_lsb();
        test_hold();
        test_reset_mid();
        test_ignore();
        test_back_to_back_w32();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
